// File: rtl/i2s_rx_pkg.sv
// Shared types for the I2S ADC receiver: FSM states, default sample width and stereo pair.
package i2s_rx_pkg;

   localparam int DATA_W_DEF = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SKIP  = 2'd1,
      SHIFT = 2'd2,
      WAIT  = 2'd3
   } rx_state_t;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] left;
      logic [DATA_W_DEF-1:0] right;
   } stereo_pair_t;

endpackage

// File: rtl/i2s_adc_rx_if.sv
// Valid/ready stereo sample stream from the I2S receiver to the filter stage.
interface i2s_adc_rx_if
   import i2s_rx_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) ();

   logic [DATA_W-1:0] sample_left;
   logic [DATA_W-1:0] sample_right;
   logic              sample_valid;
   logic              sample_ready;

   modport master (
      output sample_left,
      output sample_right,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  sample_left,
      input  sample_right,
      input  sample_valid,
      output sample_ready
   );

endinterface

// File: rtl/i2s_rx_fifo.sv
// First-word-fall-through stereo pair buffer; used by i2s_adc_rx when I2S_RX_FIFO_EN is defined.
module i2s_rx_fifo
   import i2s_rx_pkg::*;
#(
   parameter int  DEPTH  = 4,
   parameter type pair_t = stereo_pair_t
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  pair_t                  push_data,
   input  logic                   pop,
   output pair_t                  head,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int             PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0] CNT_ONE = (PTR_W + 1)'(1'b1);

   pair_t            mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] prev_ptr_s;
   logic [PTR_W:0]   count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty      = (count_r == {(PTR_W + 1){1'b0}});
   assign full       = (count_r == DEPTH_C);
   assign count      = count_r;
   assign do_pop_s   = pop && !empty;
   assign do_push_s  = push && (!full || do_pop_s);
   // While empty the slot just behind the read pointer is the last popped pair, so the output holds it.
   assign prev_ptr_s = rd_ptr_r - PTR_W'(1'b1);
   assign head       = empty ? mem_r[prev_ptr_s] : mem_r[rd_ptr_r];

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W + 1){1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S ADC receiver: synchronizes codec clocks, assembles left/right words and buffers stereo pairs.
// Define I2S_RX_FIFO_EN for a FIFO_DEPTH-entry pair buffer; otherwise a single pair register is used.
module i2s_adc_rx
   import i2s_rx_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk_clk,
   input  logic         reset_reset_n,
   input  logic         aud_bclk,
   input  logic         aud_adclrck,
   input  logic         aud_adcdat,
   i2s_adc_rx_if.master smp,
   output logic         overflow,
   input  logic         clear_overflow,
   output logic         frame_err
);

   localparam int              CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef struct packed {
      logic [DATA_W-1:0] left;
      logic [DATA_W-1:0] right;
   } pair_t;

   logic bclk_s1_r, bclk_s2_r, bclk_s3_r;
   logic lrck_s1_r, lrck_s2_r, lrck_s3_r;
   logic dat_s1_r, dat_s2_r;
   logic strobe_s, lr_edge_s, lr_fall_s;

   rx_state_t         state_r, state_nxt_s;
   logic              chan_r;
   logic [CNT_W-1:0]  bit_cnt_r;
   logic [DATA_W-1:0] shift_r, word_s;
   logic [DATA_W-1:0] left_hold_r, right_hold_r;
   logic              left_ok_r, push_r, frame_err_r, overflow_r;
   logic              shift_en_s, word_done_s, err_s, cnt_clr_s;
   pair_t             push_pair_s, head_s;
   logic              valid_s, pop_s, drop_s;

   assign strobe_s    = bclk_s2_r & ~bclk_s3_r;
   assign lr_edge_s   = lrck_s2_r ^ lrck_s3_r;
   assign lr_fall_s   = lrck_s3_r & ~lrck_s2_r;
   assign word_s      = {shift_r[DATA_W-2:0], dat_s2_r};
   assign push_pair_s = {left_hold_r, right_hold_r};

   // Input synchronizers plus edge-detect stage for the codec clocks.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         {bclk_s1_r, bclk_s2_r, bclk_s3_r} <= 3'b000;
         {lrck_s1_r, lrck_s2_r, lrck_s3_r} <= 3'b000;
         {dat_s1_r, dat_s2_r}              <= 2'b00;
      end else begin
         {bclk_s1_r, bclk_s2_r, bclk_s3_r} <= {aud_bclk, bclk_s1_r, bclk_s2_r};
         {lrck_s1_r, lrck_s2_r, lrck_s3_r} <= {aud_adclrck, lrck_s1_r, lrck_s2_r};
         {dat_s1_r, dat_s2_r}              <= {aud_adcdat, dat_s1_r};
      end
   end

   // Word framing FSM: next state and datapath controls.
   always_comb begin
      state_nxt_s = state_r;
      shift_en_s  = 1'b0;
      word_done_s = 1'b0;
      err_s       = 1'b0;
      cnt_clr_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (lr_fall_s) state_nxt_s = SKIP;
            else           state_nxt_s = IDLE;
         end
         SKIP: begin
            if (lr_edge_s) begin
               state_nxt_s = SKIP;
            end else if (strobe_s) begin
               state_nxt_s = SHIFT;
               cnt_clr_s   = 1'b1;
            end else begin
               state_nxt_s = SKIP;
            end
         end
         SHIFT: begin
            if (lr_edge_s) begin
               err_s       = 1'b1;
               state_nxt_s = SKIP;
            end else if (strobe_s) begin
               shift_en_s = 1'b1;
               if (bit_cnt_r == LAST_BIT) begin
                  word_done_s = 1'b1;
                  state_nxt_s = WAIT;
               end else begin
                  state_nxt_s = SHIFT;
               end
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         WAIT: begin
            if (lr_edge_s) state_nxt_s = SKIP;
            else           state_nxt_s = WAIT;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, shift register and channel holding registers; a pair is pushed only after a clean left word.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_r      <= IDLE;
         chan_r       <= 1'b0;
         bit_cnt_r    <= {CNT_W{1'b0}};
         shift_r      <= {DATA_W{1'b0}};
         left_hold_r  <= {DATA_W{1'b0}};
         right_hold_r <= {DATA_W{1'b0}};
         left_ok_r    <= 1'b0;
         push_r       <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         frame_err_r <= err_s;
         push_r      <= 1'b0;
         if (lr_edge_s) begin
            chan_r <= lrck_s2_r;
         end
         if (cnt_clr_s) begin
            bit_cnt_r <= {CNT_W{1'b0}};
         end else if (shift_en_s) begin
            bit_cnt_r <= bit_cnt_r + CNT_W'(1'b1);
         end
         if (shift_en_s) begin
            shift_r <= word_s;
         end
         if (err_s) begin
            left_ok_r <= 1'b0;
         end else if (word_done_s) begin
            if (!chan_r) begin
               left_hold_r <= word_s;
               left_ok_r   <= 1'b1;
            end else begin
               right_hold_r <= word_s;
               push_r       <= left_ok_r;
               left_ok_r    <= 1'b0;
            end
         end
      end
   end

   assign pop_s = valid_s && smp.sample_ready;

`ifdef I2S_RX_FIFO_EN
   logic                          fifo_empty_s;
   logic                          fifo_full_s;
   logic [$clog2(FIFO_DEPTH):0]   unused_fifo_count_s;

   i2s_rx_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .pair_t (pair_t)
   ) u_fifo (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .push      (push_r),
      .push_data (push_pair_s),
      .pop       (pop_s),
      .head      (head_s),
      .empty     (fifo_empty_s),
      .full      (fifo_full_s),
      .count     (unused_fifo_count_s)
   );

   assign valid_s = !fifo_empty_s;
   assign drop_s  = push_r && fifo_full_s && !pop_s;
`else
   pair_t pair_r;
   logic  pair_valid_r;
   logic  unused_depth_s;

   assign unused_depth_s = (FIFO_DEPTH > 1);

   // Single pair register; an unpopped pair is overwritten by the next one.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         pair_r       <= '0;
         pair_valid_r <= 1'b0;
      end else if (push_r) begin
         pair_r       <= push_pair_s;
         pair_valid_r <= 1'b1;
      end else if (pop_s) begin
         pair_valid_r <= 1'b0;
      end
   end

   assign head_s  = pair_r;
   assign valid_s = pair_valid_r;
   assign drop_s  = push_r && pair_valid_r && !pop_s;
`endif

   // Sticky overflow; a drop wins over a simultaneous clear.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else if (clear_overflow) begin
         overflow_r <= 1'b0;
      end
   end

   assign smp.sample_left  = head_s.left;
   assign smp.sample_right = head_s.right;
   assign smp.sample_valid = valid_s;
   assign overflow         = overflow_r;
   assign frame_err        = frame_err_r;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Scoreboard bench for i2s_adc_rx: drives I2S frames, models the pair buffer, compares popped pairs.
module tb_i2s_adc_rx;

   localparam int DATA_W     = 24;
   localparam int FIFO_DEPTH = 4;
   localparam int SLOT       = 32;
   localparam int HALF       = 4;
`ifdef I2S_RX_FIFO_EN
   localparam int CAP       = FIFO_DEPTH;
   localparam bit OVERWRITE = 1'b0;
`else
   localparam int CAP       = 1;
   localparam bit OVERWRITE = 1'b1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, bclk, lrck, dat, clear_overflow, overflow, frame_err;

   i2s_adc_rx_if #(.DATA_W(DATA_W)) smp ();

   i2s_adc_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk_clk        (clk),
      .reset_reset_n  (rst_n),
      .aud_bclk       (bclk),
      .aud_adclrck    (lrck),
      .aud_adcdat     (dat),
      .smp            (smp),
      .overflow       (overflow),
      .clear_overflow (clear_overflow),
      .frame_err      (frame_err)
   );

   int total = 0;
   int bad = 0;
   int pop_cnt = 0;
   int ferr_cnt = 0;
   logic [2*DATA_W-1:0] exp_q [$];
   logic exp_ovf = 1'b0;

   // Scoreboard consumer: a pair seen with valid&ready here is popped on the next rising edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && smp.sample_valid === 1'b1 && smp.sample_ready === 1'b1) begin
         logic [2*DATA_W-1:0] e;
         pop_cnt++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pair_unexpected: got %h_%h want none", smp.sample_left, smp.sample_right);
         end else begin
            e = exp_q.pop_front();
            if ({smp.sample_left, smp.sample_right} !== e) begin
               bad++;
               $display("FAIL pair_out: got %h_%h want %h_%h", smp.sample_left, smp.sample_right,
                        e[2*DATA_W-1:DATA_W], e[DATA_W-1:0]);
            end
         end
      end
      if (frame_err === 1'b1) ferr_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_chan(input logic ch, input logic [DATA_W-1:0] word, input int nslots);
      for (int k = 0; k < nslots; k++) begin
         bclk = 1'b0;
         if (k == 0) lrck = ch;
         if (k >= 1 && k <= DATA_W) dat = word[DATA_W-k];
         else                       dat = 1'b0;
         repeat (HALF) tick();
         bclk = 1'b1;
         repeat (HALF) tick();
      end
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
      send_chan(1'b0, l, SLOT);
      send_chan(1'b1, r, SLOT);
   endtask

   task automatic model_push(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
      if (exp_q.size() < CAP) begin
         exp_q.push_back({l, r});
      end else begin
         exp_ovf = 1'b1;
         if (OVERWRITE) begin
            exp_q.delete(exp_q.size() - 1);
            exp_q.push_back({l, r});
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      total += 5;
      if (smp.sample_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", smp.sample_valid); end
      if (smp.sample_left !== 24'h000000) begin bad++; $display("FAIL rst_left: got %h want 0", smp.sample_left); end
      if (smp.sample_right !== 24'h000000) begin bad++; $display("FAIL rst_right: got %h want 0", smp.sample_right); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
      if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
   endtask

   task automatic test_basic();
      int f0 = ferr_cnt;
      smp.sample_ready = 1'b0;
      model_push(24'hABCDEF, 24'h123456);
      send_frame(24'hABCDEF, 24'h123456);
      for (int c = 0; c < 50 && smp.sample_valid !== 1'b1; c++) tick();
      total += 4;
      if (smp.sample_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", smp.sample_valid); end
      if (smp.sample_left !== 24'hABCDEF) begin bad++; $display("FAIL basic_left: got %h want abcdef", smp.sample_left); end
      if (smp.sample_right !== 24'h123456) begin bad++; $display("FAIL basic_right: got %h want 123456", smp.sample_right); end
      if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL basic_frame_err: got %0d pulses want 0", ferr_cnt - f0); end
      smp.sample_ready = 1'b1;
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) tick();
      tick();
      smp.sample_ready = 1'b0;
      tick();
      total += 2;
      if (exp_q.size() != 0) begin bad++; $display("FAIL basic_drain: got %0d left want 0", exp_q.size()); end
      if (smp.sample_valid !== 1'b0) begin bad++; $display("FAIL basic_empty: got %b want 0", smp.sample_valid); end
   endtask

   task automatic test_right_first();
      int p0;
      lrck = 1'b1;
      rst_n = 1'b0;
      exp_q.delete();
      exp_ovf = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      p0 = pop_cnt;
      send_chan(1'b1, 24'hFFFFFF, SLOT);
      model_push(24'h111111, 24'h222222);
      send_frame(24'h111111, 24'h222222);
      smp.sample_ready = 1'b1;
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) tick();
      repeat (4) tick();
      smp.sample_ready = 1'b0;
      total += 2;
      if (pop_cnt - p0 !== 1) begin bad++; $display("FAIL right_first_pairs: got %0d want 1", pop_cnt - p0); end
      if (exp_q.size() != 0) begin bad++; $display("FAIL right_first_drain: got %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_overflow();
      int p0 = pop_cnt;
      smp.sample_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         model_push(DATA_W'(i * 24'h010101), DATA_W'(24'hF00000 | i));
         send_frame(DATA_W'(i * 24'h010101), DATA_W'(24'hF00000 | i));
      end
      repeat (4) tick();
      total += 2;
      if (exp_ovf !== 1'b1) begin bad++; $display("FAIL ovf_model: got %b want 1", exp_ovf); end
      if (overflow !== exp_ovf) begin bad++; $display("FAIL ovf_set: got %b want %b", overflow, exp_ovf); end
      smp.sample_ready = 1'b1;
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) tick();
      repeat (4) tick();
      smp.sample_ready = 1'b0;
      total += 3;
      if (pop_cnt - p0 !== CAP) begin bad++; $display("FAIL ovf_pairs: got %0d want %0d", pop_cnt - p0, CAP); end
      if (exp_q.size() != 0) begin bad++; $display("FAIL ovf_drain: got %0d left want 0", exp_q.size()); end
      if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      exp_ovf = 1'b0;
      total++;
      if (overflow !== exp_ovf) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
   endtask

   task automatic test_frame_err();
      int f0 = ferr_cnt;
      int p0 = pop_cnt;
      smp.sample_ready = 1'b1;
      send_chan(1'b0, 24'hAAAAAA, 11);
      send_chan(1'b1, 24'h555555, SLOT);
      total += 2;
      if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_pulse: got %0d cycles want 1", ferr_cnt - f0); end
      if (pop_cnt - p0 !== 0) begin bad++; $display("FAIL ferr_no_pair: got %0d want 0", pop_cnt - p0); end
      model_push(24'h0F0F0F, 24'hF0F0F0);
      send_frame(24'h0F0F0F, 24'hF0F0F0);
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) tick();
      repeat (4) tick();
      smp.sample_ready = 1'b0;
      total += 2;
      if (pop_cnt - p0 !== 1) begin bad++; $display("FAIL ferr_recover: got %0d want 1", pop_cnt - p0); end
      if (exp_q.size() != 0) begin bad++; $display("FAIL ferr_drain: got %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      int p0 = pop_cnt;
      smp.sample_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         model_push(DATA_W'(i), DATA_W'(24'h800000 | i));
         send_frame(DATA_W'(i), DATA_W'(24'h800000 | i));
      end
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) tick();
      repeat (4) tick();
      smp.sample_ready = 1'b0;
      total += 3;
      if (pop_cnt - p0 !== 8) begin bad++; $display("FAIL b2b_pairs: got %0d want 8", pop_cnt - p0); end
      if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d left want 0", exp_q.size()); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
   endtask

   task automatic test_reset_mid();
      int p0;
      smp.sample_ready = 1'b0;
      model_push(24'h0A0A0A, 24'h050505);
      send_frame(24'h0A0A0A, 24'h050505);
      total++;
      if (smp.sample_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid: got %b want 1", smp.sample_valid); end
      fork
         send_chan(1'b0, 24'h777777, SLOT);
         begin
            repeat (10 * 2 * HALF) tick();
            rst_n = 1'b0;
            exp_q.delete();
            exp_ovf = 1'b0;
            tick();
            total += 3;
            if (smp.sample_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", smp.sample_valid); end
            if (smp.sample_left !== 24'h000000) begin bad++; $display("FAIL rmid_left: got %h want 0", smp.sample_left); end
            if (smp.sample_right !== 24'h000000) begin bad++; $display("FAIL rmid_right: got %h want 0", smp.sample_right); end
            tick();
            rst_n = 1'b1;
         end
      join
      p0 = pop_cnt;
      send_chan(1'b1, 24'h999999, SLOT);
      model_push(24'h246802, 24'h135791);
      send_frame(24'h246802, 24'h135791);
      smp.sample_ready = 1'b1;
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) tick();
      repeat (4) tick();
      smp.sample_ready = 1'b0;
      total += 2;
      if (pop_cnt - p0 !== 1) begin bad++; $display("FAIL rmid_pairs: got %0d want 1", pop_cnt - p0); end
      if (exp_q.size() != 0) begin bad++; $display("FAIL rmid_drain: got %0d left want 0", exp_q.size()); end
   endtask

   initial begin
      rst_n            = 1'b0;
      bclk             = 1'b0;
      lrck             = 1'b1;
      dat              = 1'b0;
      clear_overflow   = 1'b0;
      smp.sample_ready = 1'b0;
      test_reset();
      test_basic();
      test_right_first();
      test_overflow();
      test_frame_err();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2s_adc_rx.md
# i2s_adc_rx

Receives the I2S serial ADC stream from the audio codec (AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT) and converts it into parallel stereo sample pairs for the filter datapath. It samples codec clocks in the system clock domain and assembles left/right words MSB-first. It buffers completed pairs behind a valid/ready handshake. It sits directly upstream of the audio core / filter stage in the nios_system audio path.

## Interface
- DATA_W, 24, sample width per channel (16..32)
- FIFO_DEPTH, 4, stereo-pair buffer depth (power of 2, ≥2)

- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset_n  in  1  reset, synchronous, active-low
- aud_bclk  in  1  codec bit clock (asynchronous)
- aud_adclrck  in  1  codec LR clock (asynchronous); low = left
- aud_adcdat  in  1  codec serial data (asynchronous)
- sample_left  out  DATA_W  head-of-buffer left sample
- sample_right  out  DATA_W  head-of-buffer right sample
- sample_valid  out  1  head pair valid
- sample_ready  in  1  consumer accepts head pair when valid & ready
- overflow  out  1  sticky: pair dropped because buffer full
- clear_overflow  in  1  clears overflow
- frame_err  out  1  one-cycle pulse: LRCK edge before DATA_W bits captured

## Operation
- aud_bclk, aud_adclrck, aud_adcdat each pass a 2-flop synchronizer; a third flop on bclk/lrck gives edge detect.
- Bit strobe = synchronized bclk rising edge. LRCK edge = change of synchronized lrck; channel = new lrck level.
- FSM states: IDLE, SKIP, SHIFT, WAIT.
  - IDLE: after reset, wait for first LRCK falling edge (start of left) -> SKIP. Right-channel starts are ignored here.
  - SKIP: discard first bit strobe (I2S one-BCLK delay) -> SHIFT, bit count = 0.
  - SHIFT: each strobe shifts aud_adcdat into channel shift register MSB-first; after DATA_W-th bit store word to left/right holding reg -> WAIT.
  - WAIT: ignore strobes until next LRCK edge -> SKIP.
  - LRCK edge in SHIFT: frame_err pulse, discard partial word, -> SKIP for new channel. Pair assembly restarts at next left.
- Push: on the clock after right word completes, and only if a valid left word from the same frame is held, the pair is pushed.
- Buffer is first-word-fall-through; outputs show head pair when sample_valid=1, else hold last value.
- Push when full and no pop in the same cycle: new pair dropped, overflow set. Push and pop in the same cycle when full: both occur.
- overflow: set on drop, cleared by clear_overflow; simultaneous set and clear -> stays set.

## Timing
- Reset: all outputs 0, FSM IDLE, buffer empty, shift/hold regs 0, overflow 0.
- Requirement: clk_clk ≥ 4× aud_bclk frequency.
- Input-to-strobe latency: 3 clk_clk cycles.
- Last right bit strobe -> sample_valid high: 2 clk_clk cycles when buffer empty.
- Pop: sample_valid & sample_ready on cycle N -> next pair (or valid=0) visible cycle N+1.
- Reset asserted mid-frame: partial data lost; resynchronizes at next left start after reset release.

## Configuration
- I2S_RX_FIFO_EN defined: FIFO_DEPTH-entry buffer as above.
- Undefined: single pair register (FIFO_DEPTH ignored). A push while valid and not popped overwrites the held pair and sets overflow.

## Structure
- Package i2s_rx_pkg: FSM state enum (IDLE, SKIP, SHIFT, WAIT), DATA_W default constant, stereo pair struct type.
- Sub-module i2s_rx_fifo: parameterized pair buffer with count, FWFT output, full/empty. Instantiated only under I2S_RX_FIFO_EN.

## Test plan
- Reset, then send left 0xABCDEF, right 0x123456 (DATA_W=24, BCLK = clk/8) -> sample_valid=1, sample_left=0xABCDEF, sample_right=0x123456, frame_err=0.
- Frame begins on right (LRCK high after reset), then a full frame -> first partial ignored; exactly one pair is output, and it comes from the full frame.
- sample_ready=0, send 5 frames with FIFO_DEPTH=4 -> 4 pairs held in order, overflow=1. clear_overflow -> overflow=0.
- LRCK toggles after 10 bits of left -> frame_err one-cycle pulse, no pair pushed; next complete frame is output correctly.
- sample_ready held 1 continuously over 8 frames of values 1..8 -> 8 pairs in order, overflow stays 0.
- reset_reset_n low for 2 cycles mid-left word -> outputs 0 next cycle; the next full frame after release is output correctly.
